// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: widths, initial hash constants, hash word array and serializer states.
`timescale 1ns/1ps
package sha_pkg;

    localparam int DIGEST_W = 256;
    localparam int WORD_W   = 32;

    localparam logic [WORD_W-1:0] H0 = 32'h6a09e667;
    localparam logic [WORD_W-1:0] H1 = 32'hbb67ae85;
    localparam logic [WORD_W-1:0] H2 = 32'h3c6ef372;
    localparam logic [WORD_W-1:0] H3 = 32'ha54ff53a;
    localparam logic [WORD_W-1:0] H4 = 32'h510e527f;
    localparam logic [WORD_W-1:0] H5 = 32'h9b05688c;
    localparam logic [WORD_W-1:0] H6 = 32'h1f83d9ab;
    localparam logic [WORD_W-1:0] H7 = 32'h5be0cd19;

    // Element [7] is h1 so the packed vector reads h1..h8 from MSB down.
    typedef logic [7:0][WORD_W-1:0] hash_words_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha_digest_serializer.sv
// Snapshots h1..h8 on start and streams the digest as OUT_W-bit beats, h1 first, MSB first.
// Define SHA_SER_BYTESWAP_EN to byte-reverse each word (little-endian stream).
`timescale 1ns/1ps
module sha_digest_serializer
    import sha_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       h1_in,
    input  logic [31:0]       h2_in,
    input  logic [31:0]       h3_in,
    input  logic [31:0]       h4_in,
    input  logic [31:0]       h5_in,
    input  logic [31:0]       h6_in,
    input  logic [31:0]       h7_in,
    input  logic [31:0]       h8_in,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output ser_state_t        state_dbg
);

    localparam int BEATS = NUM_WORDS * WORD_W / OUT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(BEATS - 1);

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // out_valid stays high from the first beat until the last one is accepted.

    ser_state_t           state;
    ser_state_t           state_nx;
    logic [DIGEST_W-1:0]  snap;
    logic [CNT_W-1:0]     beat;
    logic                 hs;
    logic                 last_k;
    hash_words_t          words;

    function automatic logic [WORD_W-1:0] fmt(input logic [WORD_W-1:0] w);
`ifdef SHA_SER_BYTESWAP_EN
        return bswap32(w);
`else
        return w;
`endif
    endfunction

    always_comb begin
        words    = '0;
        words[7] = fmt(h1_in);
        words[6] = fmt(h2_in);
        words[5] = fmt(h3_in);
        words[4] = fmt(h4_in);
        words[3] = fmt(h5_in);
        words[2] = fmt(h6_in);
        words[1] = fmt(h7_in);
        words[0] = (NUM_WORDS > 7) ? fmt(h8_in) : '0;
    end

    assign last_k    = (beat == LAST_K);
    assign hs        = (state == SEND) && out_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)        state_nx = SEND;
            SEND:    if (hs && last_k) state_nx = IDLE;
            default:                   state_nx = IDLE;
        endcase
    end

    // The snapshot shifts left on each accepted beat, so the current beat is always the top OUT_W bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap <= '0;
            beat <= '0;
            done <= 1'b0;
        end else begin
            done <= hs && last_k;
            if ((state == IDLE) && start) begin
                snap <= words;
                beat <= '0;
            end else if (hs) begin
                snap <= snap << OUT_W;
                beat <= last_k ? '0 : beat + CNT_W'(1);
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        if (state == SEND) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_last  = last_k;
            out_data  = snap[DIGEST_W-1 -: OUT_W];
        end
    end

endmodule

// File: tb/tb_sha_digest_serializer.sv
// Directed bench for sha_digest_serializer: three instances (32b/SHA-256, 8b/SHA-256, 16b/SHA-224)
// driven from a vector table plus hand sequences for mid-stream start and reset abort.
`timescale 1ns/1ps
module tb_sha_digest_serializer;
    import sha_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [31:0] h [8];
    logic        start;
    logic        ready;
    int          sel;

    logic        start_a, start_b, start_c;
    logic        ready_a, ready_b, ready_c;
    logic [31:0] data_a;
    logic [7:0]  data_b;
    logic [15:0] data_c;
    logic        valid_a, valid_b, valid_c;
    logic        last_a, last_b, last_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    ser_state_t  st_a, st_b, st_c;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);
    assign ready_a = ready && (sel == 0);
    assign ready_b = ready && (sel == 1);
    assign ready_c = ready && (sel == 2);

    sha_digest_serializer #(.OUT_W(32), .NUM_WORDS(8)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .h1_in(h[0]), .h2_in(h[1]), .h3_in(h[2]), .h4_in(h[3]),
        .h5_in(h[4]), .h6_in(h[5]), .h7_in(h[6]), .h8_in(h[7]),
        .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
        .busy(busy_a), .done(done_a), .state_dbg(st_a)
    );

    sha_digest_serializer #(.OUT_W(8), .NUM_WORDS(8)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .h1_in(h[0]), .h2_in(h[1]), .h3_in(h[2]), .h4_in(h[3]),
        .h5_in(h[4]), .h6_in(h[5]), .h7_in(h[6]), .h8_in(h[7]),
        .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
        .busy(busy_b), .done(done_b), .state_dbg(st_b)
    );

    sha_digest_serializer #(.OUT_W(16), .NUM_WORDS(7)) u_c (
        .clk(clk), .reset_n(reset_n), .start(start_c),
        .h1_in(h[0]), .h2_in(h[1]), .h3_in(h[2]), .h4_in(h[3]),
        .h5_in(h[4]), .h6_in(h[5]), .h7_in(h[6]), .h8_in(h[7]),
        .out_data(data_c), .out_valid(valid_c), .out_ready(ready_c), .out_last(last_c),
        .busy(busy_c), .done(done_c), .state_dbg(st_c)
    );

    logic [31:0] cur_data;
    logic        cur_valid, cur_last, cur_busy, cur_done;
    ser_state_t  cur_st;

    always_comb begin
        cur_data  = 32'h0;
        cur_valid = valid_a;
        cur_last  = last_a;
        cur_busy  = busy_a;
        cur_done  = done_a;
        cur_st    = st_a;
        case (sel)
            0: cur_data = data_a;
            1: begin
                cur_data  = {24'h0, data_b};
                cur_valid = valid_b; cur_last = last_b; cur_busy = busy_b;
                cur_done  = done_b;  cur_st   = st_b;
            end
            default: begin
                cur_data  = {16'h0, data_c};
                cur_valid = valid_c; cur_last = last_c; cur_busy = busy_c;
                cur_done  = done_c;  cur_st   = st_c;
            end
        endcase
    end

    // scoreboard
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int beat_w(input int s);
        return (s == 0) ? 32 : (s == 1) ? 8 : 16;
    endfunction

    // Reference model: builds the expected beat list from the words present at start.
    task automatic model_load(input int s);
        int          bw;
        int          nw;
        logic [31:0] w;
        logic [31:0] mask;
        bw   = beat_w(s);
        nw   = (s == 2) ? 7 : 8;
        mask = 32'hffffffff >> (32 - bw);
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            w = h[i];
`ifdef SHA_SER_BYTESWAP_EN
            w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
            for (int j = 0; j < 32 / bw; j++)
                exp_q.push_back((w >> (32 - (j + 1) * bw)) & mask);
        end
    endtask

    // driver: one full digest, mode 0 = ready held high, mode 1 = ready toggles 1/0
    task automatic run_vec(input int s, input int mode, input int inject,
                           input logic [31:0] exp_first, input logic [31:0] exp_lastb,
                           input int exp_beats, input string tag);
        int          beats;
        int          cyc;
        logic        rdy_t;
        logic        injected;
        logic [31:0] e;
        sel      = s;
        model_load(s);
        beats    = 0;
        cyc      = 0;
        rdy_t    = 1'b1;
        injected = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(cur_busy), 32'd1);
        check({tag, " state_send"}, 32'(cur_st), 32'(SEND));
        while (beats < exp_beats && cyc < 400) begin
            ready = (mode == 0) ? 1'b1 : rdy_t;
            rdy_t = ~rdy_t;
            start = 1'b0;
            if (inject >= 0 && beats == inject && !injected) begin
                h[0]     = 32'hdeadbeef;
                start    = 1'b1;
                injected = 1'b1;
            end
            check({tag, " valid_held"}, 32'(cur_valid), 32'd1);
            if (exp_q.size() > 0)
                check($sformatf("%s data_beat%0d", tag, beats), cur_data, exp_q[0]);
            if (ready) begin
                e = exp_q.pop_front();
                check($sformatf("%s last_beat%0d", tag, beats), 32'(cur_last),
                      32'(exp_q.size() == 0));
                if (beats == 0) check({tag, " first_beat"}, cur_data, exp_first);
                if (beats == exp_beats - 1) check({tag, " final_beat"}, cur_data, exp_lastb);
                if (e !== cur_data) begin end
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;
        if (cyc >= 400) check({tag, " timeout_beats"}, 32'(beats), 32'(exp_beats));
        check({tag, " busy_after_last"}, 32'(cur_busy), 32'd0);
        check({tag, " valid_after_last"}, 32'(cur_valid), 32'd0);
        check({tag, " done_pulse"}, 32'(cur_done), 32'd1);
        @(negedge clk);
        check({tag, " done_clears"}, 32'(cur_done), 32'd0);
    endtask

    typedef struct {
        int          s;
        int          mode;
        int          use_abc;
        logic [31:0] first;
        logic [31:0] lastb;
        int          beats;
    } vec_t;

    vec_t vt[4];

    logic [31:0] hinit [8];
    logic [31:0] habc  [8];

    task automatic load_words(input int use_abc);
        for (int i = 0; i < 8; i++) h[i] = use_abc ? habc[i] : hinit[i];
    endtask

    initial begin
        hinit = '{H0, H1, H2, H3, H4, H5, H6, H7};
        habc  = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                  32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
`ifdef SHA_SER_BYTESWAP_EN
        vt[0] = '{0, 0, 0, 32'h67e6096a, 32'h19cde05b, 8};
        vt[1] = '{1, 1, 1, 32'h000000bf, 32'h000000f2, 32};
        vt[2] = '{2, 0, 0, 32'h000067e6, 32'h0000831f, 14};
        vt[3] = '{2, 1, 1, 32'h0000bf16, 32'h000010b4, 14};
`else
        vt[0] = '{0, 0, 0, 32'h6a09e667, 32'h5be0cd19, 8};
        vt[1] = '{1, 1, 1, 32'h000000ba, 32'h000000ad, 32};
        vt[2] = '{2, 0, 0, 32'h00006a09, 32'h0000d9ab, 14};
        vt[3] = '{2, 1, 1, 32'h0000ba78, 32'h0000ff61, 14};
`endif
        reset_n = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        sel     = 0;
        load_words(0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("rst%0d valid", s), 32'(cur_valid), 32'd0);
            check($sformatf("rst%0d busy", s), 32'(cur_busy), 32'd0);
            check($sformatf("rst%0d last", s), 32'(cur_last), 32'd0);
            check($sformatf("rst%0d done", s), 32'(cur_done), 32'd0);
            check($sformatf("rst%0d data", s), cur_data, 32'd0);
            check($sformatf("rst%0d state", s), 32'(cur_st), 32'(IDLE));
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sel = 0;
        #1;
        check("post_rst valid", 32'(cur_valid), 32'd0);

        // table-driven digests
        for (int v = 0; v < 4; v++) begin
            load_words(vt[v].use_abc);
            run_vec(vt[v].s, vt[v].mode, -1, vt[v].first, vt[v].lastb, vt[v].beats,
                    $sformatf("vec%0d", v));
        end

        // start and h1 change mid-stream are ignored; the next start picks up the new h1
        load_words(0);
        run_vec(0, 0, 3, vt[0].first, vt[0].lastb, 8, "midstart");
`ifdef SHA_SER_BYTESWAP_EN
        run_vec(0, 0, -1, 32'hefbeadde, vt[0].lastb, 8, "newh1");
`else
        run_vec(0, 0, -1, 32'hdeadbeef, vt[0].lastb, 8, "newh1");
`endif

        // reset during beat 5 aborts without done, then a fresh start begins at beat 0
        load_words(0);
        sel = 0;
        model_load(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b1;
        repeat (4) @(negedge clk);
        ready = 1'b0;
        check("abort beat5_data", cur_data, exp_q[4]);
        #2 reset_n = 1'b0;
        #1;
        check("abort valid", 32'(cur_valid), 32'd0);
        check("abort busy", 32'(cur_busy), 32'd0);
        check("abort last", 32'(cur_last), 32'd0);
        check("abort data", cur_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort no_done%0d", i), 32'(cur_done), 32'd0);
            check($sformatf("abort idle%0d", i), 32'(cur_valid), 32'd0);
        end
        run_vec(0, 0, -1, vt[0].first, vt[0].lastb, 8, "restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sha_digest_serializer.md
Name: sha_digest_serializer

Overview:
Reader side of the SHA-256 hash-state register. It snapshots the eight 32-bit hash words h1..h8 on a start pulse, then streams the digest out as OUT_W-bit beats over a valid/ready handshake, with h1 first and MSB first. It sits between the compression core's state register and the bus/UART output path.

Parameters:
OUT_W, 32, beat width in bits; legal values are 8, 16 and 32.
NUM_WORDS, 8, number of hash words emitted; 8 gives SHA-256, 7 gives SHA-224 (h8 is never sent).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous reset, active-low.
start  input  1  one-cycle request to capture and send the digest.
h1_in..h8_in  input  32 each  current hash state words.
out_data  output  OUT_W  current beat.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream accepts the beat.
out_last  output  1  the current beat is the final beat.
busy  output  1  a capture or stream is in progress.
done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Clocking and reset: single clock domain clk. reset_n is asynchronous and active-low.
- While reset_n is low, and on reset_n deassertion:
  - out_data=0, out_valid=0, out_last=0, busy=0, done=0.
  - Snapshot register and beat counter are 0.
  - FSM is in IDLE.
- Beats per digest: BEATS = NUM_WORDS*32/OUT_W (8/16/32 for SHA-256; 7/14/28 for SHA-224). Beat counter width is $clog2(BEATS).
- FSM states: IDLE and SEND.
- IDLE:
  - busy=0, out_valid=0.
  - start=1 captures {h1_in..h8_in} into a 256-bit snapshot and moves to SEND.
  - First beat appears with out_valid=1 on the next cycle (latency 1).
- SEND:
  - busy=1, out_valid=1.
  - out_data = snapshot bits [255 - k*OUT_W -: OUT_W] for beat k.
  - A handshake is out_valid && out_ready. Each handshake advances k by one on the next edge.
  - Without a handshake, out_data, out_last and k hold stable. out_valid never drops mid-stream.
  - out_last=1 only when k == BEATS-1.
  - The handshake on the last beat returns the FSM to IDLE, clears k and out_valid, and pulses done=1 in the following cycle.
- start while busy is ignored and the snapshot is unchanged. Changes on h*_in after capture do not affect the stream.
- start in the same cycle as a done pulse is accepted, because the FSM is in IDLE. A back-to-back digest then costs one idle cycle.
- out_ready held high gives one beat per cycle. out_ready=0 indefinitely stalls the stream with no timeout.
- reset_n asserted mid-stream aborts the stream immediately to reset values, with no done pulse.
- NUM_WORDS=7: snapshot bits for h8 are ignored and the stream ends after the h7 beats.

Optional Feature:
- Macro: SHA_SER_BYTESWAP_EN.
- Defined: each 32-bit word is byte-reversed before slicing, giving a little-endian digest stream. With OUT_W=32 the first beat for h1=6a09e667 is 67e6096a.
- Undefined: big-endian order as above. With OUT_W=32 the first beat is 6a09e667.
- busy, done, out_last and handshake timing are identical in both builds.

Decomposition:
- Shared package sha_pkg holds:
  - DIGEST_W=256 and WORD_W=32.
  - SHA-256 initial constants H0..H7 (6a09e667 .. 5be0cd19).
  - Typedef for the 8-word hash array.
  - Serializer state enum {IDLE, SEND}.
- No sub-module is needed. Snapshot slicing and the beat counter stay inline in a single module of about 150 lines.

Test Plan:
1. Reset then start with the SHA-256 initial constants, OUT_W=32, out_ready=1 -> 8 consecutive beats 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19. out_last on beat 8 only. done pulses one cycle after beat 8. busy falls with the last handshake.
2. Digest of "abc" (ba7816bf .. f20015ad), OUT_W=8, out_ready toggled 1/0 each cycle -> 32 bytes ba, 78, 16, bf, ... ad. Each byte held stable through stalls with no duplicates. out_last only on 0xad.
3. Change h1_in to deadbeef on beat 3 and pulse start mid-stream -> stream unchanged and the second start ignored. The next start after done sends deadbeef first.
4. Assert reset_n low during beat 5 -> out_valid, busy and out_last go to 0 asynchronously with no done pulse. A following start restarts at beat 0.
5. NUM_WORDS=7, OUT_W=16 -> 14 beats with out_last on beat 14. The h8 value never appears.
6. SHA_SER_BYTESWAP_EN defined, OUT_W=32, initial constants -> first beat 67e6096a, last beat 19cde05b, timing identical to scenario 1.
